alu_wb_buffer: RTL and testbench

- Receiving end of the ALU's one-cycle registered result interface.
- The ALU registers `result_o` and `alu_branch_res_o` but carries no valid or transaction ID. This block tracks issue valid and trans_id through the ALU's one-cycle latency and pairs them with the returning result.
- Paired results are queued in a DEPTH-entry FIFO and presented to the writeback arbiter with a valid/ready handshake.
- Back-pressure is returned to issue through `alu_ready_o`.

---
 rtl/alu_wb_buffer.sv | 112 +++++++++++
 tb/tb_alu_wb_buffer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_wb_buffer.sv
// Pairs the ALU's registered result with its issue trans_id and queues it for writeback.
// Optional same-cycle forwarding into an empty buffer: define ALU_WB_BYPASS_EN.
module alu_wb_buffer #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     alu_valid_i,
  input  logic [TRANS_ID_BITS-1:0] alu_trans_id_i,
  output logic                     alu_ready_o,
  input  logic [XLEN-1:0]          alu_result_i,
  input  logic                     alu_branch_res_i,
  output logic                     wb_valid_o,
  output logic [TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic [XLEN-1:0]          wb_result_o,
  output logic                     wb_branch_res_o,
  input  logic                     wb_ready_i,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [XLEN-1:0]          result;
    logic                     branch_res;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } entry_t;

  entry_t                   r_mem [DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;
  logic                     r_s1_valid;
  logic [TRANS_ID_BITS-1:0] r_s1_id;

  entry_t           w_in_entry;
  entry_t           w_head;
  logic             w_empty;
  logic             w_accept;
  logic             w_push;
  logic             w_fifo_pop;
  logic             w_bypass;
  logic [CNT_W-1:0] w_occupancy;

  assign w_empty     = (r_count == '0);
  // NOTE: the op in stage 1 already owns a slot; a same-cycle pop earns no credit,
  // so a push can never find the FIFO full.
  assign w_occupancy = r_count + CNT_W'(r_s1_valid);
  assign alu_ready_o = (w_occupancy < CNT_W'(DEPTH));
  assign w_accept    = alu_valid_i & alu_ready_o & ~flush_i;
  assign w_in_entry  = '{result: alu_result_i, branch_res: alu_branch_res_i, trans_id: r_s1_id};

`ifdef ALU_WB_BYPASS_EN
  assign w_bypass = w_empty & r_s1_valid & ~flush_i;
`else
  assign w_bypass = 1'b0;
`endif

  // A forwarded entry taken by writeback in the same cycle never enters storage.
  assign w_push     = r_s1_valid & ~flush_i & ~(w_bypass & wb_ready_i);
  assign w_fifo_pop = ~w_empty & wb_ready_i & ~flush_i;
  assign w_head     = w_bypass ? w_in_entry : r_mem[r_rd_ptr];

  assign wb_valid_o      = ~w_empty | w_bypass;
  assign wb_trans_id_o   = w_head.trans_id;
  assign wb_result_o     = w_head.result;
  assign wb_branch_res_o = w_head.branch_res;
  assign count_o         = r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_id    <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else if (flush_i) begin
      r_s1_valid <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) r_s1_id <= alu_trans_id_i;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_fifo_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_fifo_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is reset so the head fields read as zero straight out of reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= w_in_entry;
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && (r_count == CNT_W'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_fifo_pop && w_empty));

endmodule

// File: tb/tb_alu_wb_buffer.sv
// Directed bench for alu_wb_buffer: stimulus pushes expected entries into a queue,
// a negedge monitor compares the head against the queue front whenever wb_valid_o is high.
module tb_alu_wb_buffer;
  localparam int XLEN  = 64;
  localparam int TID   = 3;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            flush_i;
  logic            alu_valid_i;
  logic [TID-1:0]  alu_trans_id_i;
  logic            alu_ready_o;
  logic [XLEN-1:0] alu_result_i;
  logic            alu_branch_res_i;
  logic            wb_valid_o;
  logic [TID-1:0]  wb_trans_id_o;
  logic [XLEN-1:0] wb_result_o;
  logic            wb_branch_res_o;
  logic            wb_ready_i;
  logic [$clog2(DEPTH):0] count_o;

  logic [XLEN-1:0] op_res;
  logic            op_br;

  typedef struct {
    logic [TID-1:0]  id;
    logic [XLEN-1:0] res;
    logic            br;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  alu_wb_buffer #(.XLEN(XLEN), .TRANS_ID_BITS(TID), .DEPTH(DEPTH)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .flush_i         (flush_i),
    .alu_valid_i     (alu_valid_i),
    .alu_trans_id_i  (alu_trans_id_i),
    .alu_ready_o     (alu_ready_o),
    .alu_result_i    (alu_result_i),
    .alu_branch_res_i(alu_branch_res_i),
    .wb_valid_o      (wb_valid_o),
    .wb_trans_id_o   (wb_trans_id_o),
    .wb_result_o     (wb_result_o),
    .wb_branch_res_o (wb_branch_res_o),
    .wb_ready_i      (wb_ready_i),
    .count_o         (count_o)
  );

  always #5 clk = ~clk;

  // One-cycle registered ALU: the result for an op issued in cycle N is visible in N+1.
  always @(posedge clk) begin
    alu_result_i     <= op_res;
    alu_branch_res_i <= op_br;
  end

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [TID-1:0] t_id, input logic [XLEN-1:0] t_res,
                       input logic t_br, input logic t_acc);
    exp_t e;
    alu_valid_i    = 1'b1;
    alu_trans_id_i = t_id;
    op_res         = t_res;
    op_br          = t_br;
    if (t_acc) begin
      e.id  = t_id;
      e.res = t_res;
      e.br  = t_br;
      exp_q.push_back(e);
    end
  endtask

  task automatic idle();
    alu_valid_i    = 1'b0;
    alu_trans_id_i = '0;
    op_res         = 64'hBAD0_BAD0_BAD0_BAD0;
    op_br          = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst_i && !flush_i && wb_valid_o) begin
      if (exp_q.size() == 0) begin
        check("wb_valid_unexpected", wb_valid_o, 0);
      end else begin
        check("wb_id", wb_trans_id_o, exp_q[0].id);
        check("wb_result", wb_result_o, exp_q[0].res);
        check("wb_branch", wb_branch_res_o, exp_q[0].br);
        if (wb_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish long before", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_i      = 1'b1;
    flush_i    = 1'b0;
    wb_ready_i = 1'b0;
    idle();

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_wb_id", wb_trans_id_o, 0);
    check("rst_wb_result", wb_result_o, 0);
    check("rst_wb_branch", wb_branch_res_o, 0);
    check("rst_count", count_o, 0);
    check("rst_ready", alu_ready_o, 1);
    #2 rst_i = 1'b0;

    // Single op: issue at N, head valid at N+2, drained at N+3.
    next_cycle();
    wb_ready_i = 1'b1;
    drive(3'd5, 64'h0000_0000_DEAD_BEEF, 1'b1, 1'b1);
    @(negedge clk);
    check("single_ready", alu_ready_o, 1);
    next_cycle();
    idle();
    @(negedge clk);
    check("single_valid_n1", wb_valid_o, 0);
    next_cycle();
    @(negedge clk);
    check("single_valid_n2", wb_valid_o, 1);
    check("single_count_n2", count_o, 1);
    next_cycle();
    @(negedge clk);
    check("single_count_n3", count_o, 0);
    check("single_valid_n3", wb_valid_o, 0);

    // Streaming ids 0..7 back to back with writeback always ready.
    for (int k = 0; k < 12; k++) begin
      next_cycle();
      if (k < 8) drive(k[2:0], 64'hA5A5_0000_0000_0000 | 64'(k), k[0], 1'b1);
      else idle();
      @(negedge clk);
      check("stream_ready", alu_ready_o, 1);
      check("stream_count_le1", count_o <= 1, 1);
      if (k >= 2 && k < 10) check("stream_wb_valid", wb_valid_o, 1);
    end

    // Back-pressure: exactly four accepts, then ready drops and the head holds.
    wb_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      drive(3'(k + 1), 64'hF000 + 64'(k), ~k[0], k < 4);
      @(negedge clk);
      check("full_ready", alu_ready_o, k < 4);
    end
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      idle();
      @(negedge clk);
      check("full_count", count_o, 4);
      check("full_ready_hold", alu_ready_o, 0);
      check("full_head_id", wb_trans_id_o, 1);
    end
    next_cycle();
    wb_ready_i = 1'b1;
    repeat (4) next_cycle();
    @(negedge clk);
    check("full_drain_count", count_o, 0);
    check("full_drain_queue", exp_q.size(), 0);

    // Steady push+pop at count 2; ten ops wrap both pointers.
    wb_ready_i = 1'b0;
    for (int t = 0; t < 14; t++) begin
      next_cycle();
      wb_ready_i = (t >= 3);
      if (t < 10) drive(3'(t), 64'h7700 + 64'(t), t[1], 1'b1);
      else idle();
      @(negedge clk);
      if (t >= 3 && t <= 11) check("pp_count2", count_o, 2);
      if (t < 10) check("pp_ready", alu_ready_o, 1);
    end

    // Alternating writeback ready with sparse issue.
    for (int t = 0; t < 12; t++) begin
      next_cycle();
      wb_ready_i = t[0];
      if (t % 2 == 0 && t < 8) drive(3'(t / 2 + 4), 64'h5A00_0000_0000_0000 + 64'(t), t[2], 1'b1);
      else idle();
    end
    next_cycle();
    wb_ready_i = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    check("alt_drain_queue", exp_q.size(), 0);

    // Flush with three queued entries and one in stage 1; issue in the flush cycle is ignored.
    wb_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      drive(3'(k + 2), 64'hF1F1_0000 + 64'(k), 1'b0, 1'b1);
    end
    next_cycle();
    flush_i = 1'b1;
    exp_q.delete();
    drive(3'd7, 64'hDEAD_0007, 1'b1, 1'b0);
    @(negedge clk);
    check("flush_pre_count", count_o, 3);
    check("flush_pre_ready", alu_ready_o, 0);
    next_cycle();
    flush_i    = 1'b0;
    wb_ready_i = 1'b1;
    idle();
    @(negedge clk);
    check("flush_valid", wb_valid_o, 0);
    check("flush_count", count_o, 0);
    check("flush_ready", alu_ready_o, 1);
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      check("flush_quiet", wb_valid_o, 0);
    end

    // Op accepted into an empty buffer, flushed while its result is returning.
    next_cycle();
    drive(3'd3, 64'hABCD, 1'b1, 1'b0);
    next_cycle();
    flush_i = 1'b1;
    idle();
    next_cycle();
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_inflight_valid", wb_valid_o, 0);
    check("flush_inflight_count", count_o, 0);
    next_cycle();
    @(negedge clk);
    check("flush_inflight_quiet", wb_valid_o, 0);

    // Asynchronous reset between edges with entries queued and one in flight.
    wb_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      drive(3'(k + 1), 64'hC0DE_0000 + 64'(k), 1'b1, 1'b1);
    end
    next_cycle();
    idle();
    @(negedge clk);
    check("arst_pre_count", count_o, 2);
    #2;
    rst_i = 1'b1;
    exp_q.delete();
    #1;
    check("arst_valid", wb_valid_o, 0);
    check("arst_count", count_o, 0);
    check("arst_ready", alu_ready_o, 1);
    check("arst_id", wb_trans_id_o, 0);
    check("arst_result", wb_result_o, 0);
    @(negedge clk);
    #2 rst_i = 1'b0;

    next_cycle();
    wb_ready_i = 1'b1;
    drive(3'd6, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b1);
    next_cycle();
    idle();
    @(negedge clk);
    check("post_rst_valid_n1", wb_valid_o, 0);
    next_cycle();
    @(negedge clk);
    check("post_rst_valid_n2", wb_valid_o, 1);
    next_cycle();
    @(negedge clk);
    check("post_rst_count", count_o, 0);

    repeat (2) next_cycle();
    check("final_queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
